l1_pool_streamer: RTL and testbench

- Downstream stage of the convolution/max-pool engine.
- Once layer-1 (32x32 max-pooled, 1024 x 20-bit words, csel=3'b011 bank) has been written, reads the bank sequentially and emits it as a valid/ready stream to the readout/next-layer interface.
- Hides the 1-cycle synchronous memory read latency with a 2-entry output FIFO and credit-based read issue, so throughput is 1 word/cycle under no backpressure and nothing is lost or duplicated under backpressure.

---
 rtl/l1_pool_streamer.sv | 138 +++++++++++++
 tb/tb_l1_pool_streamer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/l1_pool_streamer.sv
// l1_pool_streamer: reads the layer-1 max-pool bank (csel 3'b011) and emits it as a valid/ready stream.
// Optional running checksum output is enabled by defining L1_STREAM_CHECKSUM_EN.
module l1_pool_streamer #(
  parameter int DATA_W     = 20,
  parameter int N_WORDS    = 1024,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [2:0]        rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [ADDR_W-1:0] out_index
`ifdef L1_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W+ADDR_W-1:0] checksum
`endif
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q;
  logic              inflight_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic              pop, push, fifo_empty, start_acc;
  logic [CNT_W-1:0]  inflight_w, pop_w, credit_used;

  assign fifo_empty  = (count_q == '0);
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign push        = inflight_q;
  assign start_acc   = (state_q == IDLE) && start;
  assign inflight_w  = {{(CNT_W-1){1'b0}}, inflight_q};
  assign pop_w       = {{(CNT_W-1){1'b0}}, pop};
  // Credits count both buffered words and the read whose data lands next cycle.
  assign credit_used = count_q + inflight_w - pop_w;

  assign out_data  = fifo_empty ? '0 : fifo_q[rptr_q];
  assign out_index = idx_q;
  assign out_last  = out_valid && (idx_q == LAST_ADDR);
  assign rd_addr   = addr_q;
  assign rd_sel    = rd_en ? 3'b011 : 3'b000;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          addr_d  = '0;
        end
      end
      RUN: begin
        rd_en = (credit_used < DEPTH_C);
        if (rd_en) begin
          if (addr_q == LAST_ADDR) state_d = DRAIN;
          else                     addr_d  = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // Leave as the final word pops so done lands in the very next cycle.
        if (!inflight_q && (count_q == pop_w)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      idx_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= rd_en;
      if (start_acc)  idx_q <= '0;
      else if (pop)   idx_q <= idx_q + 1'b1;
      if (push) wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Buffer storage carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= rd_data;
  end

`ifdef L1_STREAM_CHECKSUM_EN
  logic [DATA_W+ADDR_W-1:0] sum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         sum_q <= '0;
    else if (start_acc) sum_q <= '0;
    else if (pop)       sum_q <= sum_q + {{ADDR_W{1'b0}}, out_data};
  end

  assign checksum = sum_q;
`endif

`ifndef SYNTHESIS
  credit_bound: assert property (@(posedge clk) disable iff (!reset)
    (count_q + inflight_w) <= DEPTH_C);
`endif

endmodule

// File: tb/tb_l1_pool_streamer.sv
// Bench for l1_pool_streamer: table of frame scenarios run against a sequential-memory model and
// an in-order expected-word reference; checksum checks are compiled when L1_STREAM_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_l1_pool_streamer;
  localparam int DATA_W     = 20;
  localparam int N_WORDS    = 1024;
  localparam int ADDR_W     = 10;
  localparam int FIFO_DEPTH = 2;
  localparam int BUDGET     = 6000;

  typedef struct {
    int     pat;         // 0: mem[i]=i, 1: all ones, 2: random
    int     rmode;       // 0: ready high, 1: random ready
    int     hold0;       // cycles with ready forced low after start
    int     restart_at;  // word index at which a second start is pulsed (-1 none)
    int     reset_at;    // word index at which reset is asserted (-1 none)
    int     exp_words;
    int     exp_done;
    longint exp_sum;     // -1: use model sum only
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic busy, done, rd_en, out_valid, out_last;
  logic [2:0]        rd_sel;
  logic [ADDR_W-1:0] rd_addr, out_index;
  logic [DATA_W-1:0] rd_data, out_data;
`ifdef L1_STREAM_CHECKSUM_EN
  logic [DATA_W+ADDR_W-1:0] checksum;
`endif

  logic [DATA_W-1:0] mem [N_WORDS];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  l1_pool_streamer #(
    .DATA_W(DATA_W), .N_WORDS(N_WORDS), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_index(out_index)
`ifdef L1_STREAM_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // Synchronous bank: data appears one cycle after the strobe, garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : DATA_W'($urandom);

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic outs_nonzero();
    logic nz;
    nz = busy | done | rd_en | out_valid | out_last | (rd_sel != 3'b000) |
         (rd_addr != '0) | (out_data != '0) | (out_index != '0);
`ifdef L1_STREAM_CHECKSUM_EN
    nz = nz | (checksum != '0);
`endif
    return nz;
  endfunction

  task automatic fill(input int pat);
    for (int i = 0; i < N_WORDS; i++) begin
      case (pat)
        0:       mem[i] = DATA_W'(i);
        1:       mem[i] = 20'hFFFFF;
        default: mem[i] = DATA_W'($urandom);
      endcase
    end
  endtask

  task automatic run_frame(input vec_t v, input int vi);
    int idx = 0, k = 0, n_done = 0, post = 0;
    int k_first_pop = -1, k_last_pop = -1, k_done = -1, k_first_valid = -1;
    int hold_rd = 0, n_issue = 0, bad_sel = 0;
    bit restarted = 0, aborted = 0, prev_stall = 0;
    logic [DATA_W-1:0] prev_data = '0;
    longint sum = 0;
    string tag;
    tag = $sformatf("v%0d", vi);

    @(negedge clk);
    check({tag, " idle_busy"}, busy, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    while (k < BUDGET) begin
      @(negedge clk);
      k++;
      if (v.reset_at >= 0 && idx == v.reset_at) begin
        reset = 1'b0;
        #1;
        check({tag, " abort_outputs_zero"}, outs_nonzero(), 0);
        repeat (4) begin
          @(negedge clk);
          if (done) n_done++;
        end
        reset = 1'b1;
        aborted = 1;
        break;
      end
      if (k <= v.hold0)       out_ready = 1'b0;
      else if (v.rmode == 0)  out_ready = 1'b1;
      else                    out_ready = 1'($urandom_range(0, 1));
      if (v.restart_at >= 0 && !restarted && idx == v.restart_at) begin
        start = 1'b1;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      #1;

      if (k == 1) begin
        check({tag, " busy_after_start"}, busy, 1);
        check({tag, " first_rd_en"}, rd_en, 1);
        check({tag, " first_rd_addr"}, rd_addr, 0);
      end
      if (rd_en) n_issue++;
      if (rd_sel != (rd_en ? 3'b011 : 3'b000)) bad_sel++;
      if (k <= v.hold0 && rd_en) hold_rd++;
      if (v.hold0 > 0 && k == v.hold0) begin
        check({tag, " hold_valid"}, out_valid, 1);
        check({tag, " hold_data"}, out_data, mem[0]);
      end
      if (out_valid && k_first_valid < 0) k_first_valid = k;
      if (prev_stall) begin
        check({tag, " stall_valid"}, out_valid, 1);
        check({tag, " stall_data"}, out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (idx >= N_WORDS) begin
          check({tag, " extra_transfer"}, idx + 1, N_WORDS);
        end else begin
          check($sformatf("%s data[%0d]", tag, idx), out_data, mem[idx]);
          check($sformatf("%s index[%0d]", tag, idx), out_index, idx);
          check($sformatf("%s last[%0d]", tag, idx), out_last, (idx == N_WORDS - 1));
        end
        sum += longint'(out_data);
        if (k_first_pop < 0) k_first_pop = k;
        k_last_pop = k;
        idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;

      if (done) begin
        n_done++;
        if (k_done < 0) begin
          k_done = k;
          check({tag, " busy_with_done"}, busy, 1);
          check({tag, " done_after_last_pop"}, k_done - k_last_pop, 1);
`ifdef L1_STREAM_CHECKSUM_EN
          check({tag, " checksum_model"}, checksum, sum);
          if (v.exp_sum >= 0) check({tag, " checksum_const"}, checksum, v.exp_sum);
`endif
        end
      end
      if (k_done >= 0 && k > k_done) begin
        check({tag, " busy_low_after_done"}, busy, 0);
`ifdef L1_STREAM_CHECKSUM_EN
        check({tag, " checksum_stable"}, checksum, sum);
`endif
        post++;
        if (post == 2) break;
      end
    end

    check({tag, " words"}, idx, v.exp_words);
    check({tag, " done_pulses"}, n_done, v.exp_done);
    check({tag, " rd_sel_bad_cycles"}, bad_sel, 0);
    if (!aborted) begin
      check({tag, " within_budget"}, (k < BUDGET), 1);
      check({tag, " issues"}, n_issue, N_WORDS);
      check({tag, " first_valid_cycle"}, k_first_valid, 3);
      if (v.rmode == 0) check({tag, " full_rate_span"}, k_last_pop - k_first_pop, N_WORDS - 1);
    end
    if (v.hold0 > 0)
      check($sformatf("%s hold_rd_en_count=%0d_le_2", tag, hold_rd), (hold_rd <= FIFO_DEPTH), 1);
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{0, 0, 0,  -1,  -1, 1024, 1, 64'd523776};
    vecs[1] = '{0, 1, 0,  -1,  -1, 1024, 1, 64'd523776};
    vecs[2] = '{0, 0, 20, -1,  -1, 1024, 1, 64'd523776};
    vecs[3] = '{2, 1, 0,  500, -1, 1024, 1, -64'sd1};
    vecs[4] = '{0, 1, 0,  -1,  300, 300, 0, -64'sd1};
    vecs[5] = '{0, 0, 0,  -1,  -1, 1024, 1, 64'd523776};
    vecs[6] = '{1, 0, 0,  -1,  -1, 1024, 1, 64'h3FFFFC00};

    // Power-on reset: every output low while reset is held.
    #2;
    check("reset_outputs_zero", outs_nonzero(), 0);
    repeat (3) @(negedge clk);
    check("reset_held_idle", busy, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_done_low", done, 0);
    check("post_reset_valid_low", out_valid, 0);

    for (int i = 0; i < 7; i++) begin
      fill(vecs[i].pat);
      run_frame(vecs[i], i);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
